// File: rtl/keypad_time_loader_if.sv
// Keypad digit/display bundle between the encoder side (master) and the time loader (slave).
interface keypad_time_loader_if;
  logic [3:0] bcd;
  logic       loadn;
  logic       lock;
  logic       clear_entry;
  logic [3:0] mins_tens;
  logic [3:0] mins_ones;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic [2:0] digit_count;
  logic       full;
  logic       time_valid;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output bcd, loadn, lock, clear_entry,
    input  mins_tens, mins_ones, secs_tens, secs_ones, digit_count, full, time_valid, seg, an
  );

  modport slave (
    input  bcd, loadn, lock, clear_entry,
    output mins_tens, mins_ones, secs_tens, secs_ones, digit_count, full, time_valid, seg, an
  );
endinterface

// File: rtl/keypad_time_loader.sv
// Shifts keypad digits into an MM:SS entry register and scans it onto a 4-digit 7-seg display.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros (slot0 always shown).
module keypad_time_loader #(
  parameter int SCAN_DIV = 1000,
  parameter int SCAN_W   = 10
) (
  input logic                clk,
  input logic                clearn,
  keypad_time_loader_if.slave kif
);

  logic            s1, s2, s3;
  logic [3:0]      b1, b2;
  logic [3:0][3:0] dig;
  logic [2:0]      cnt;
  logic            full, accept, take;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
      b1 <= 4'd0; b2 <= 4'd0;
    end else begin
      s1 <= kif.loadn; s2 <= s1; s3 <= s2;
      b1 <= kif.bcd;   b2 <= b1;
    end
  end

  // One accept per press: rising edge of the synchronized strobe.
  assign accept = s2 & ~s3;
  assign full   = (cnt == 3'd4);
  assign take   = accept & ~kif.lock & (b2 <= 4'd9) & ~full;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      dig <= '0;
      cnt <= 3'd0;
    end else if (kif.clear_entry) begin
      dig <= '0;
      cnt <= 3'd0;
    end else if (take) begin
      dig <= {dig[2:0], b2};
      cnt <= cnt + 3'd1;
    end
  end

  assign kif.mins_tens   = dig[3];
  assign kif.mins_ones   = dig[2];
  assign kif.secs_tens   = dig[1];
  assign kif.secs_ones   = dig[0];
  assign kif.digit_count = cnt;
  assign kif.full        = full;
  assign kif.time_valid  = (dig[1] <= 4'd5);

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  logic [SCAN_W-1:0] pre;
  logic [1:0]        slot, nslot;
  logic [3:0]        blank;
  logic [6:0]        nseg;
  logic [6:0]        seg_q;
  logic [3:0]        an_q;

  assign nslot = slot + 2'd1;

  // Segment pattern for the slot about to be entered, so seg and an switch together.
  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    blank[3] = (dig[3] == 4'd0);
    for (int i = 2; i >= 1; i--) blank[i] = blank[i+1] & (dig[i] == 4'd0);
`endif
    nseg = blank[nslot] ? 7'b1111111 : seg_code(dig[nslot]);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      pre   <= '0;
      slot  <= 2'd0;
      an_q  <= 4'b1110;
      seg_q <= 7'b1000000;
    end else if (pre == SCAN_W'(SCAN_DIV - 1)) begin
      pre   <= '0;
      slot  <= nslot;
      an_q  <= ~(4'b0001 << nslot);
      seg_q <= nseg;
    end else begin
      pre <= pre + SCAN_W'(1);
    end
  end

  assign kif.seg = seg_q;
  assign kif.an  = an_q;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Self-checking bench: entry value/count model plus display scan reference.
module tb_keypad_time_loader;
  logic clk = 1'b0;
  logic clearn = 1'b1;
  keypad_time_loader_if kif();

  keypad_time_loader #(.SCAN_DIV(4), .SCAN_W(2)) dut (
    .clk(clk), .clearn(clearn), .kif(kif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mval = 0;
  int mcnt = 0;
  logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [20:0] obs;

  assign obs = {kif.mins_tens, kif.mins_ones, kif.secs_tens, kif.secs_ones,
                kif.digit_count, kif.full, kif.time_valid};

  function automatic int pow10(int s);
    int p = 1;
    for (int i = 0; i < s; i++) p = p * 10;
    return p;
  endfunction

  function automatic int dig_of(int v, int s);
    return (v / pow10(s)) % 10;
  endfunction

  function automatic logic [20:0] exp_state();
    return {4'(dig_of(mval, 3)), 4'(dig_of(mval, 2)), 4'(dig_of(mval, 1)), 4'(dig_of(mval, 0)),
            3'(mcnt), (mcnt == 4), (dig_of(mval, 1) <= 5)};
  endfunction

  function automatic logic [6:0] exp_seg(int slot);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && mval < pow10(slot)) return 7'b1111111;
`endif
    return codes[dig_of(mval, slot)];
  endfunction

  // One key press starting at a negedge; lock and clear are per-cycle so the
  // accept edge (third posedge of the press) is the only one that matters.
  task automatic press(input logic [3:0] d, input int hold, input int gap,
                       input logic [7:0] lkm, input bit clr);
    for (int c = 0; c < hold + gap; c++) begin
      kif.bcd         = d;
      kif.loadn       = (c < hold);
      kif.lock        = (c < 8) ? lkm[c] : 1'b0;
      kif.clear_entry = clr && (c == 2);
      @(negedge clk);
    end
    kif.lock = 1'b0;
    kif.clear_entry = 1'b0;
    if (clr) begin
      mval = 0; mcnt = 0;
    end else if (!lkm[2] && d <= 4'd9 && mcnt < 4) begin
      mval = mval * 10 + int'(d); mcnt++;
    end
  endtask

  task automatic clear_pulse();
    kif.clear_entry = 1'b1;
    @(negedge clk);
    kif.clear_entry = 1'b0;
    mval = 0; mcnt = 0;
  endtask

  task automatic test_reset();
    #1 clearn = 1'b0;
    #1;
    checks++;
    if ({obs, kif.an, kif.seg} !== {exp_state(), 4'b1110, 7'b1000000}) begin
      failures++;
      $display("FAIL reset_initial got=%h want=%h", {obs, kif.an, kif.seg}, {exp_state(), 4'b1110, 7'b1000000});
    end
    @(negedge clk); clearn = 1'b1;
    press(4'd4, 3, 3, 8'h00, 1'b0);
    press(4'd2, 3, 3, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    #2 clearn = 1'b0;
    mval = 0; mcnt = 0;
    #1;
    checks++;
    if ({obs, kif.an, kif.seg} !== {exp_state(), 4'b1110, 7'b1000000}) begin
      failures++;
      $display("FAIL reset_async got=%h want=%h", {obs, kif.an, kif.seg}, {exp_state(), 4'b1110, 7'b1000000});
    end
    @(negedge clk); clearn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic [3:0] seq [3] = '{4'd1, 4'd3, 4'd0};
    logic [20:0] prev;
    for (int n = 0; n < 3; n++) begin
      kif.bcd = seq[n]; kif.loadn = 1'b1;
      prev = exp_state();
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (obs !== prev) begin
        failures++;
        $display("FAIL latency_early[%0d] got=%h want=%h", n, obs, prev);
      end
      mval = mval * 10 + int'(seq[n]); mcnt++;
      @(posedge clk); #1;
      checks++;
      if (obs !== exp_state()) begin
        failures++;
        $display("FAIL latency_edge3[%0d] got=%h want=%h", n, obs, exp_state());
      end
      repeat (2) @(posedge clk);
      @(negedge clk); kif.loadn = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_full_clear();
    logic [3:0] seq [5] = '{4'd9, 4'd0, 4'd0, 4'd0, 4'd7};
    clear_pulse();
    foreach (seq[i]) press(seq[i], 5, 5, 8'h00, 1'b0);
    checks++;
    if (obs !== exp_state() || mval != 9000) begin
      failures++;
      $display("FAIL full_hold got=%h want=%h", obs, exp_state());
    end
    press(4'd3, 5, 5, 8'h00, 1'b1);
    checks++;
    if (obs !== exp_state()) begin
      failures++;
      $display("FAIL clear_over_accept got=%h want=%h", obs, exp_state());
    end
    press(4'd8, 3, 3, 8'h00, 1'b0);
    kif.lock = 1'b1;
    clear_pulse();
    kif.lock = 1'b0;
    checks++;
    if (obs !== exp_state()) begin
      failures++;
      $display("FAIL clear_while_locked got=%h want=%h", obs, exp_state());
    end
  endtask

  task automatic test_hold_bad_lock();
    press(4'd5, 50, 3, 8'h00, 1'b0);
    checks++;
    if (obs !== exp_state()) begin
      failures++;
      $display("FAIL long_hold got=%h want=%h", obs, exp_state());
    end
    press(4'hC, 5, 5, 8'h00, 1'b0);
    checks++;
    if (obs !== exp_state()) begin
      failures++;
      $display("FAIL bad_bcd got=%h want=%h", obs, exp_state());
    end
    press(4'd6, 5, 5, 8'hFF, 1'b0);
    checks++;
    if (obs !== exp_state()) begin
      failures++;
      $display("FAIL locked got=%h want=%h", obs, exp_state());
    end
    press(4'd7, 5, 5, 8'b1111_1011, 1'b0);
    press(4'd2, 5, 5, 8'b0000_0100, 1'b0);
    checks++;
    if (obs !== exp_state()) begin
      failures++;
      $display("FAIL lock_mid_press got=%h want=%h", obs, exp_state());
    end
  endtask

  task automatic test_time_valid();
    logic [3:0] a [4] = '{4'd0, 4'd1, 4'd7, 4'd5};
    logic [3:0] b [4] = '{4'd0, 4'd1, 4'd3, 4'd0};
    clear_pulse();
    foreach (a[i]) press(a[i], 3, 3, 8'h00, 1'b0);
    checks++;
    if (obs !== exp_state() || kif.time_valid !== 1'b0) begin
      failures++;
      $display("FAIL tv_0175 got=%h want=%h", obs, exp_state());
    end
    clear_pulse();
    foreach (b[i]) press(b[i], 3, 3, 8'h00, 1'b0);
    checks++;
    if (obs !== exp_state() || kif.time_valid !== 1'b1) begin
      failures++;
      $display("FAIL tv_0130 got=%h want=%h", obs, exp_state());
    end
  endtask

  task automatic test_scan();
    logic [3:0] ent [3][4] = '{'{4'd0, 4'd1, 4'd0, 4'd5}, '{4'd0, 4'd0, 4'd0, 4'd0}, '{4'd0, 4'd0, 4'd0, 4'd0}};
    for (int k = 0; k < 4; k++) ent[2][k] = 4'($urandom_range(0, 9));
    for (int s = 0; s < 3; s++) begin
      logic [3:0] prev_an;
      bit found = 1'b0;
      clear_pulse();
      for (int k = 0; k < 4; k++) press(ent[s][k], 3, 3, 8'h00, 1'b0);
      repeat (20) @(negedge clk);
      prev_an = kif.an;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        if (kif.an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
        else prev_an = kif.an;
      end
      checks++;
      if (!found) begin
        failures++;
        $display("FAIL scan_sync[%0d] got=an_%b want=an_1110_within_40", s, kif.an);
      end
      for (int i = 0; i < 32; i++) begin
        int sl = (i / 4) % 4;
        checks++;
        if ({kif.an, kif.seg} !== {~(4'b0001 << sl), exp_seg(sl)}) begin
          failures++;
          $display("FAIL scan[%0d] val=%0d slot=%0d got=%b_%b want=%b_%b", s, mval, sl,
                   kif.an, kif.seg, ~(4'b0001 << sl), exp_seg(sl));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [3:0] d = 4'($urandom_range(0, 15));
      int hold = $urandom_range(1, 4);
      int gap = $urandom_range(2, 4);
      logic [7:0] lkm = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      bit clr = ($urandom_range(0, 9) == 0);
      press(d, hold, gap, lkm, clr);
      checks++;
      if (obs !== exp_state()) begin
        failures++;
        $display("FAIL random[%0d] d=%0d lk=%b clr=%0d got=%h want=%h", n, d, lkm, clr, obs, exp_state());
      end
    end
  endtask

  initial begin
    kif.bcd = 4'd0; kif.loadn = 1'b0; kif.lock = 1'b0; kif.clear_entry = 1'b0;
    test_reset();
    test_latency();
    test_full_clear();
    test_hold_bad_lock();
    test_time_valid();
    test_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
